// File: rtl/hack_fetch_unit.sv
// Instruction fetch stage. It steers the external program counter and streams
// {pc, instruction} pairs from ROM into a small prefetch FIFO.
module hack_fetch_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             rom_req,
  output logic [WIDTH-1:0] rom_addr,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [WIDTH-1:0] drain_addr_reg, drain_addr_next;
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic             push, pop;
  logic [CW-1:0]    post_count;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    drain_addr_next = drain_addr_reg;
    case (state_reg)
      IDLE: begin
        if (!jump && (count_reg < FULL)) state_next = BUSY;
      end
      BUSY: begin
        if (jump) begin
          if (rom_ack) begin
            state_next = IDLE;
          end else begin
            // The un-acked request must finish at its original address.
            state_next      = DRAIN;
            drain_addr_next = pc_out;
          end
        end else if (rom_ack) begin
          state_next = (post_count < FULL) ? BUSY : IDLE;
        end
      end
      DRAIN: begin
        if (!jump && rom_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rom_req  = (state_reg != IDLE);
    rom_addr = (state_reg == DRAIN) ? drain_addr_reg : pc_out;
    pc_load  = jump;
    pc_in    = jump_target;
    pc_inc   = (state_reg == BUSY) && rom_ack && !jump;
  end

  assign push        = pc_inc;
  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && instr_ready && !jump;
  assign post_count  = count_reg + CW'(push) - CW'(pop);

  // A redirect flushes the FIFO and beats any same-cycle push or pop.
  always_comb begin
    count_next  = post_count;
    wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    if (jump) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      drain_addr_reg <= '0;
    end else begin
      count_reg      <= count_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      drain_addr_reg <= drain_addr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= pc_out;
      instr_mem[wr_ptr_reg] <= rom_data;
    end
  end

  assign instr    = instr_mem[rd_ptr_reg];
  assign instr_pc = pc_mem[rd_ptr_reg];

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Bench for hack_fetch_unit: models the PC register and a ROM with a
// programmable ack latency (ROM[a] = a + 100) and scoreboards fetched pairs.
module tb_hack_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] pc_out;
  logic [15:0] pc_in;
  logic        pc_load;
  logic        pc_inc;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  bit rom_en;
  int rom_lat;
  int rom_wait;
  int ack_cnt;
  int total;
  int bad;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  hack_fetch_unit #(.WIDTH(16), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .pc_out(pc_out), .pc_in(pc_in),
    .pc_load(pc_load), .pc_inc(pc_inc), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .jump(jump), .jump_target(jump_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program counter shares the system reset
  always @(posedge clock or posedge reset) begin
    if (reset)        pc_out <= 16'd0;
    else if (pc_load) pc_out <= pc_in;
    else if (pc_inc)  pc_out <= pc_out + 16'd1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset)                    rom_wait <= 0;
    else if (rom_req && !rom_ack) rom_wait <= rom_wait + 1;
    else                          rom_wait <= 0;
  end

  always @(posedge clock or posedge reset) begin
    if (reset)        ack_cnt <= 0;
    else if (rom_ack) ack_cnt <= ack_cnt + 1;
  end

  assign rom_ack  = rom_en && rom_req && (rom_wait >= rom_lat);
  assign rom_data = rom_addr + 16'd100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = pc + 16'd100;
    exp_q.push_back(e);
  endtask

  // Consumer side of the scoreboard
  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready && !jump) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pop observed=%0h/%0h expected=none", instr_pc, instr);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_pc", {16'd0, instr_pc}, {16'd0, e.pc});
        chk("pop_instr", {16'd0, instr}, {16'd0, e.data});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Mid-cycle reset: outputs must clear before the next clock edge
  task automatic do_reset();
    @(negedge clock);
    #1;
    reset       = 1'b1;
    jump        = 1'b0;
    rom_en      = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("rst_rom_req", {31'd0, rom_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    step(2);
  endtask

  task automatic wait_acks(input int n, input int budget);
    for (int k = 0; k < budget && ack_cnt < n; k++) step(1);
    chk("ack_wait", ack_cnt, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; jump = 1'b0; jump_target = 16'd0;
    rom_en = 1'b0; rom_lat = 0; instr_ready = 1'b0;
    step(2);

    // Streaming with zero-latency ROM
    do_reset();
    rom_lat = 0; rom_en = 1'b1; instr_ready = 1'b1;
    push_exp(16'd0); push_exp(16'd1); push_exp(16'd2);
    reset = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stream_pc_inc", {31'd0, pc_inc}, 32'd1);
      chk("stream_addr", {16'd0, rom_addr}, i);
      step(1);
    end
    rom_en = 1'b0;
    step(2);
    chk("stream_q_empty", exp_q.size(), 0);

    // Latency 3 with backpressure
    do_reset();
    rom_lat = 3; rom_en = 1'b1; instr_ready = 1'b0;
    reset = 1'b0;
    step(1);
    chk("lat_req", {31'd0, rom_req}, 32'd1);
    chk("lat_addr0", {16'd0, rom_addr}, 32'd0);
    step(2);
    @(negedge clock);
    chk("lat_hold_inc", {31'd0, pc_inc}, 32'd0);
    chk("lat_addr_stable", {16'd0, rom_addr}, 32'd0);
    step(1);
    @(negedge clock);
    chk("lat_ack_inc", {31'd0, pc_inc}, 32'd1);
    step(1);
    chk("lat_valid_n1", {31'd0, instr_valid}, 32'd1);
    chk("lat_pc_n1", {16'd0, pc_out}, 32'd1);
    step(8);
    chk("bp_req_drop", {31'd0, rom_req}, 32'd0);
    chk("bp_pc", {16'd0, pc_out}, 32'd2);
    chk("bp_acks", ack_cnt, 2);
    push_exp(16'd0); push_exp(16'd1); push_exp(16'd2);
    instr_ready = 1'b1;
    wait_acks(3, 30);
    rom_en = 1'b0;
    step(3);
    chk("bp_q_empty", exp_q.size(), 0);
    chk("bp_next_addr", {16'd0, rom_addr}, 32'd3);

    // Jump in IDLE, then jump with an outstanding request
    do_reset();
    rom_lat = 0; rom_en = 1'b0; instr_ready = 1'b1;
    jump = 1'b1; jump_target = 16'd5;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_jump_load", {31'd0, pc_load}, 32'd1);
    chk("idle_jump_inc", {31'd0, pc_inc}, 32'd0);
    chk("idle_jump_req", {31'd0, rom_req}, 32'd0);
    step(1);
    jump = 1'b0;
    @(negedge clock);
    chk("idle_jump_stay", {31'd0, rom_req}, 32'd0);
    chk("idle_jump_pc", {16'd0, pc_out}, 32'd5);
    step(1);
    @(negedge clock);
    chk("req5_addr", {16'd0, rom_addr}, 32'd5);
    step(1);
    jump = 1'b1; jump_target = 16'd40;
    @(negedge clock);
    chk("drain_jump_load", {31'd0, pc_load}, 32'd1);
    chk("drain_jump_in", {16'd0, pc_in}, 32'd40);
    chk("drain_jump_inc", {31'd0, pc_inc}, 32'd0);
    step(1);
    jump = 1'b0;
    @(negedge clock);
    chk("drain_req", {31'd0, rom_req}, 32'd1);
    chk("drain_addr", {16'd0, rom_addr}, 32'd5);
    chk("drain_pc", {16'd0, pc_out}, 32'd40);
    step(1);
    chk("drain_addr_hold", {16'd0, rom_addr}, 32'd5);
    push_exp(16'd40);
    rom_en = 1'b1;
    @(negedge clock);
    chk("drain_no_inc", {31'd0, pc_inc}, 32'd0);
    wait_acks(2, 20);
    rom_en = 1'b0;
    step(2);
    chk("jump_q_empty", exp_q.size(), 0);

    // Jump coincident with ack
    do_reset();
    rom_lat = 0; rom_en = 1'b0; instr_ready = 1'b1;
    jump = 1'b1; jump_target = 16'd7;
    reset = 1'b0;
    step(1);
    jump = 1'b0;
    step(1);
    rom_en = 1'b1; jump = 1'b1; jump_target = 16'd3;
    @(negedge clock);
    chk("coin_addr", {16'd0, rom_addr}, 32'd7);
    chk("coin_load", {31'd0, pc_load}, 32'd1);
    chk("coin_no_inc", {31'd0, pc_inc}, 32'd0);
    step(1);
    jump = 1'b0;
    @(negedge clock);
    chk("coin_empty", {31'd0, instr_valid}, 32'd0);
    chk("coin_no_drain", {31'd0, rom_req}, 32'd0);
    chk("coin_pc", {16'd0, pc_out}, 32'd3);
    push_exp(16'd3);
    wait_acks(2, 20);
    rom_en = 1'b0;
    step(2);
    chk("coin_q_empty", exp_q.size(), 0);

    // Full FIFO: pop and jump together
    do_reset();
    rom_lat = 0; rom_en = 1'b1; instr_ready = 1'b0;
    reset = 1'b0;
    wait_acks(2, 20);
    rom_en = 1'b0;
    @(negedge clock);
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    chk("full_req_drop", {31'd0, rom_req}, 32'd0);
    step(1);
    instr_ready = 1'b1; jump = 1'b1; jump_target = 16'd60;
    step(1);
    jump = 1'b0; instr_ready = 1'b0;
    @(negedge clock);
    chk("flush_wins", {31'd0, instr_valid}, 32'd0);
    chk("flush_pc", {16'd0, pc_out}, 32'd60);

    // One entry: pop and push together keep count at 1
    step(1);
    rom_en = 1'b1;
    step(1);
    instr_ready = 1'b1;
    push_exp(16'd60); push_exp(16'd61);
    @(negedge clock);
    chk("pp_inc", {31'd0, pc_inc}, 32'd1);
    chk("pp_valid", {31'd0, instr_valid}, 32'd1);
    step(1);
    rom_en = 1'b0; instr_ready = 1'b0;
    @(negedge clock);
    chk("pp_count1", {31'd0, instr_valid}, 32'd1);
    chk("pp_head_pc", {16'd0, instr_pc}, 32'd61);
    step(1);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    @(negedge clock);
    chk("pp_drained", {31'd0, instr_valid}, 32'd0);
    chk("pp_q_empty", exp_q.size(), 0);

    // Reset with a full FIFO
    do_reset();
    rom_lat = 0; rom_en = 1'b1; instr_ready = 1'b0;
    reset = 1'b0;
    step(4);
    @(negedge clock);
    chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hack_fetch_unit.md
Name: hack_fetch_unit

Overview:
- Instruction fetch stage wrapped around the 16-bit program counter (PC).
- Drives the PC's `in`/`load`/`inc` controls and consumes its `out`.
- Reads instructions from ROM over a req/ack handshake and buffers {pc, instruction} pairs in a small FIFO for the decode/execute stage.
- Accepts jump redirects from execute, flushing buffered and in-flight fetches.

Parameters:
- WIDTH, 16, address and instruction width
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pc_out  input  WIDTH  current PC value (PC `out`)
- pc_in  output  WIDTH  PC load value (PC `in`)
- pc_load  output  1  PC load strobe
- pc_inc  output  1  PC increment strobe
- rom_req  output  1  ROM read request
- rom_addr  output  WIDTH  ROM read address
- rom_ack  input  1  ROM data valid this cycle
- rom_data  input  WIDTH  ROM read data
- jump  input  1  redirect request from execute
- jump_target  input  WIDTH  redirect address
- instr  output  WIDTH  FIFO head instruction
- instr_pc  output  WIDTH  address of FIFO head
- instr_valid  output  1  FIFO non-empty
- instr_ready  input  1  consumer accepts head

Behaviour:
- Clock is `clock`; reset is `reset`, asynchronous and active-high. The PC's own reset is tied to the same system reset.
- **Reset values:** state=IDLE, FIFO count=0, drain_addr=0, instr_valid=0. The combinational outputs follow from these values; with jump=0 they are rom_req=0, pc_load=0, pc_inc=0.
- **States:**
  - IDLE: rom_req=0.
  - BUSY: rom_req=1, rom_addr=pc_out.
  - DRAIN: rom_req=1, rom_addr=drain_addr.
- **IDLE transitions:**
  - → BUSY when count<DEPTH and jump=0.
  - Otherwise stay in IDLE.
- **BUSY, no jump:**
  - rom_ack=1: push {pc_out, rom_data}; pc_inc=1 (same cycle, combinational); stay BUSY if post-push count<DEPTH, else → IDLE.
  - rom_ack=0: hold; rom_addr stays stable.
  - Zero-latency ROM gives 1 instruction/cycle.
- **BUSY, jump=1:**
  - Drives pc_load=1, pc_in=jump_target, pc_inc=0, and flushes the FIFO (count=0 at edge).
  - With rom_ack=1: data discarded, → IDLE.
  - With rom_ack=0: drain_addr←pc_out (pre-jump value), → DRAIN.
- **DRAIN:**
  - rom_req held with drain_addr until rom_ack.
  - Acked data discarded, → IDLE.
  - No pc_inc in DRAIN.
  - A further jump in DRAIN reloads the PC and flushes again; the state stays DRAIN.
- **jump in IDLE:** pc_load=1, flush, stay IDLE.
- **Priority:** jump > rom_ack > instr_ready. pc_load and pc_inc are never both 1.
- **ROM protocol:** once rom_req rises, rom_req and rom_addr stay stable until the rom_ack cycle. Outside BUSY/DRAIN, rom_ack is ignored.
- **FIFO:**
  - Head appears on instr/instr_pc with instr_valid=(count≠0).
  - Pop when instr_valid & instr_ready.
  - Push+pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push never occurs when full, because a request is issued only when count<DEPTH.
  - Pop with jump in the same cycle: flush wins; count=0 next cycle.
- **Latency:** ack at cycle N gives instr_valid=1 at N+1, and pc_out is incremented at N+1.
- **Reset mid-operation:** immediate return to IDLE with an empty FIFO; any outstanding ROM ack is ignored.

Test Plan:
- **Reset:** assert reset mid-clock → rom_req=0, instr_valid=0, pc_load=pc_inc=0 immediately, before the next edge.
- **Streaming, ack tied high, ROM[a]=a+100, instr_ready=1:** release reset with PC=0 → instr/instr_pc = 100/0, 101/1, 102/2 on consecutive cycles; pc_inc high every BUSY cycle.
- **Latency and backpressure:** ROM ack 3 cycles after req, instr_ready=0 → exactly DEPTH(2) entries fetched (pc 0,1), rom_req drops, PC=2. Then raise instr_ready → fetching resumes at 2.
- **Jump during outstanding request:** req at pc=5 un-acked, jump=1 with target=40 → pc_load pulse, PC=40, rom_addr stays 5 until ack. Data for 5 is never presented; next instr_pc=40.
- **Jump coincident with ack:** ack for pc=7 and jump with target=3 in the same cycle → FIFO empty next cycle, no drain, next fetched instr_pc=3, no pc_inc that cycle.
- **Pop/push/flush collisions:** FIFO full with pop and jump in the same cycle → count=0. FIFO at 1 with pop and ack in the same cycle → count stays 1, order preserved.
